d_mem_responder: RTL

//   Data-memory responder: serves load/store requests from the memory stage's data-memory interface.

---
 rtl/d_mem_responder_if.sv | 25 ++
 rtl/d_mem_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/d_mem_responder_if.sv
// Data-memory request/response bundle between the memory stage
// and the data-memory responder.
interface d_mem_responder_if #(
   parameter int ADDRESS_BITS = 20,
   parameter int DATA_WIDTH   = 32
);
   logic                    read;
   logic                    write;
   logic [ADDRESS_BITS-1:0] address;
   logic [DATA_WIDTH-1:0]   in_data;
   logic                    ready;
   logic                    valid;
   logic [ADDRESS_BITS-1:0] out_addr;
   logic [DATA_WIDTH-1:0]   out_data;

   modport master (
      output read, write, address, in_data,
      input  ready, valid, out_addr, out_data
   );

   modport slave (
      input  read, write, address, in_data,
      output ready, valid, out_addr, out_data
   );
endinterface

// File: rtl/d_mem_responder.sv
// Single-ported data-memory responder with programmable access latency
// and one valid pulse per accepted load/store.
module d_mem_responder #(
   parameter int CORE         = 0,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20,
   parameter int DEPTH_BITS   = 10,
   parameter int LATENCY      = 2
) (
   input  logic             clock,
   input  logic             reset,
   d_mem_responder_if.slave bus,
   input  logic             report
);

   localparam int WORDS = 1 << DEPTH_BITS;
   localparam logic [3:0] LAT_INIT =
      (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t                  state_q, state_d;
   logic                    ready_q, ready_d;
   logic                    valid_q, valid_d;
   logic [3:0]              lat_cnt_q, lat_cnt_d;
   logic [ADDRESS_BITS-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    op_q, op_d;
   logic [ADDRESS_BITS-1:0] out_addr_q, out_addr_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic [31:0]             cycles_q, cycles_d;

   logic [DATA_WIDTH-1:0]   mem [WORDS];
   logic [DEPTH_BITS-1:0]   idx;

   assign idx = addr_q[DEPTH_BITS-1:0];

   always_comb begin
      state_d    = state_q;
      ready_d    = ready_q;
      valid_d    = 1'b0;
      lat_cnt_d  = lat_cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      op_d       = op_q;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      cycles_d   = cycles_q + 32'd1;
      unique case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (ready_q && (bus.read || bus.write)) begin
               addr_d  = bus.address;
               data_d  = bus.in_data;
               op_d    = bus.write;
               ready_d = 1'b0;
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d   = WAIT;
                  lat_cnt_d = LAT_INIT;
               end
            end
         end
         WAIT: begin
            ready_d = 1'b0;
            if (lat_cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         RESP: begin
            valid_d    = 1'b1;
            ready_d    = 1'b1;
            state_d    = IDLE;
            out_addr_d = addr_q;
            out_data_d = op_q ? data_q : mem[idx];
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         valid_q    <= 1'b0;
         lat_cnt_q  <= 4'd0;
         addr_q     <= '0;
         data_q     <= '0;
         op_q       <= 1'b0;
         out_addr_q <= '0;
         out_data_q <= '0;
         cycles_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         valid_q    <= valid_d;
         lat_cnt_q  <= lat_cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         op_q       <= op_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         cycles_q   <= cycles_d;
      end
   end

   // Storage is not cleared by reset; a reset edge aborts a pending store.
   always_ff @(posedge clock) begin
      if (!reset && state_q == RESP && op_q) begin
         mem[idx] <= data_q;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.valid    = valid_q;
   assign bus.out_addr = out_addr_q;
   assign bus.out_data = out_data_q;

`ifndef SYNTHESIS
   always_ff @(posedge clock) begin
      if (!reset && state_q == RESP && report) begin
         $display("core %0d cycle %0d %s addr %h data %h",
                  CORE, cycles_q, op_q ? "W" : "R",
                  addr_q, out_data_d);
      end
   end
`endif

endmodule
